// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with lock bursts in front of the single-port dmem.
// Define DMEM_ARB_FIXED_PRIO_EN to make the core port (A) win all idle conflicts.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t            state;
    logic [3:0]        burst_cnt;
    logic              prefer_b;
    logic              xfer_a;
    logic              xfer_b;
    logic              xfer;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        cnt_base;
    logic [3:0]        cnt_next;
    logic              keep;
    logic              q1_b;
    logic              q2_v;
    logic              q2_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign prefer_b = 1'b0;
`else
    logic rr_b;
    assign prefer_b = rr_b;
`endif

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (state == LOCK_A && a_req) begin
                a_gnt = 1'b1;
            end else if (state == LOCK_B && b_req) begin
                b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                a_gnt = !prefer_b;
                b_gnt = prefer_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    assign xfer_a    = a_req && a_gnt;
    assign xfer_b    = b_req && b_gnt;
    assign xfer      = xfer_a || xfer_b;
    assign sel_we    = xfer_b ? b_we    : a_we;
    assign sel_lock  = xfer_b ? b_lock  : a_lock;
    assign sel_addr  = xfer_b ? b_addr  : a_addr;
    assign sel_wdata = xfer_b ? b_wdata : a_wdata;

    // A transfer by the non-owner during a released lock starts a fresh count.
    assign cnt_base = ((state == LOCK_A && xfer_a) ||
                       (state == LOCK_B && xfer_b)) ? burst_cnt : 4'd0;
    assign cnt_next = cnt_base + 4'd1;
    assign keep     = sel_lock && (cnt_next < BMAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_b      <= 1'b0;
`endif
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            q1_b      <= 1'b0;
            q2_v      <= 1'b0;
            q2_b      <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (xfer) begin
                if (keep) begin
                    state     <= xfer_b ? LOCK_B : LOCK_A;
                    burst_cnt <= cnt_next;
                end else begin
                    state     <= IDLE;
                    burst_cnt <= 4'd0;
                end
`ifndef DMEM_ARB_FIXED_PRIO_EN
                rr_b <= xfer_a;
`endif
            end else if (state != IDLE) begin
                state     <= IDLE;
                burst_cnt <= 4'd0;
            end

            mem_en <= xfer;
            mem_we <= xfer && sel_we;
            if (xfer) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                q1_b      <= xfer_b;
            end

            // Read pipe: mem stage, SRAM output stage, return.
            q2_v     <= mem_en && !mem_we;
            q2_b     <= q1_b;
            a_rvalid <= q2_v && !q2_b;
            b_rvalid <= q2_v && q2_b;
            if (q2_v && !q2_b) a_rdata <= mem_rdata;
            if (q2_v && q2_b)  b_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the core's single-port synchronous data memory between the core load/store unit (port A) and the debug/loader port (port B). The loader uses port B to preload or inspect dmem while the core runs.
- Sits between riscv_core's data interface and the dmem SRAM macro.
- Provides valid/ready request handshakes, round-robin arbitration, bounded lock bursts and fixed-latency read return.

Parameters:
- ADDR_W, 8, word-address width of dmem.
- DATA_W, 32, data width.
- BURST_MAX, 4, maximum consecutive locked transfers before forced hand-over (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  port A request valid.
- a_we  input  1  port A write enable (0 = read).
- a_lock  input  1  port A requests to keep ownership for the next transfer.
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  port A ready; transfer occurs on an edge with a_req && a_gnt.
- a_rvalid  output  1  port A read data valid, one-cycle pulse.
- a_rdata  output  DATA_W  port A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_en  output  1  SRAM access strobe.
- mem_we  output  1  SRAM write enable.
- mem_addr  output  ADDR_W  SRAM address.
- mem_wdata  output  DATA_W  SRAM write data.
- mem_rdata  input  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. All state changes occur on the rising edge of clk.
- Reset values:
  - All gnt, rvalid, mem_en and mem_we are 0.
  - mem_addr, mem_wdata, a_rdata and b_rdata are 0.
  - State is IDLE, the round-robin pointer favours A, and burst_cnt is 0.
- States:
  - IDLE (no owner).
  - LOCK_A: A granted last and asserted a_lock.
  - LOCK_B: symmetric for B.
- Grant generation is combinational from state, req and the RR pointer. At most one gnt is high per cycle; gnt is 0 when its req is 0.
- In IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port indicated by the RR pointer is granted.
  - After each accepted transfer, the pointer moves to the other port.
- LOCK_X:
  - X is granted exclusively while x_req = 1.
  - If x_req = 0, fall back to IDLE rules in the same cycle; the lock is released.
- Transitions (on an accepted transfer by X):
  - x_lock = 1 and burst_cnt+1 < BURST_MAX: go to LOCK_X and increment burst_cnt.
  - Otherwise: go to IDLE, clear burst_cnt, and point RR at the other port.
- A locked burst therefore contains at most BURST_MAX transfers. If the other port is waiting, it is granted on the next transfer slot.
- Memory side:
  - mem_en, mem_we, mem_addr and mem_wdata are registered copies of the accepted transfer, driven the cycle after the acceptance edge.
  - mem_en is 0 in cycles following an edge with no transfer.
- Read return:
  - x_rvalid pulses exactly 2 cycles after the acceptance edge, with x_rdata = mem_rdata.
  - x_rdata holds its value when rvalid is 0.
  - Writes produce no rvalid.
- Throughput: one transfer per cycle. Back-to-back reads from alternating ports return in acceptance order.
- Read-after-write to the same address on consecutive transfers returns the new data; the SRAM is write-first.
- Reset asserted mid-operation:
  - In-flight read returns are discarded, with no rvalid after reset.
  - Lock, burst_cnt and the RR pointer return to reset values.
  - No gnt is asserted in a cycle where reset = 1.
- Unused requester signals are don't-care when req = 0. x_addr, x_we and x_wdata must be stable while x_req && !x_gnt.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined:
  - In IDLE, A (core) always wins when both request, and the RR pointer is not implemented.
  - LOCK_B still guarantees B its burst, up to BURST_MAX.
- Undefined: round-robin as described above.

Test Plan:
- After reset, A reads addr 0x05 (SRAM preloaded with 0x0000000F): a_gnt = 1 the same cycle, mem_en/mem_addr = 0x05 the next cycle, a_rvalid = 1 with a_rdata = 0x0000000F two cycles after acceptance; b_rvalid stays 0.
- A and B both hold req with lock = 0 for 6 cycles: grants alternate A, B, A, B, A, B; each read returns to the correct port with its own address's data.
- B requests with b_lock = 1 while A requests continuously, BURST_MAX = 4: B gets 4 consecutive grants, then A is granted; with DMEM_ARB_FIXED_PRIO_EN undefined, the RR pointer then favours B.
- B writes 0x00000020 to addr 0x00, then A reads addr 0x00 the next cycle: a_rdata = 0x00000020.
- A read is accepted, then reset is asserted on the next edge for 1 cycle: no a_rvalid ever appears; state returns to IDLE with the RR pointer at A; all outputs are 0.
- With DMEM_ARB_FIXED_PRIO_EN defined, A and B both request for 3 cycles with lock = 0: a_gnt = 1 all 3 cycles and b_gnt = 0; B is granted in the first cycle a_req = 0.
